stm_pair_collector: RTL and testbench

- Downstream consumer of the two-phase state-machine stage.
- Samples that stage's 32-bit output stream and groups consecutive words into (phase-A, phase-B) pairs.
- Buffers pairs in a small FIFO and presents them on a valid/ready interface for the next consumer.
- Tracks dropped pairs when the consumer stalls too long.

---
 rtl/stm_pair_collector_if.sv | 29 ++
 rtl/stm_pair_collector.sv | 101 ++++++++++
 tb/tb_stm_pair_collector.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/stm_pair_collector_if.sv
// Pair-collector bus: upstream word stream, clear strobe, and the downstream
// valid/ready pair port with its occupancy/drop status.
interface stm_pair_collector_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic [WIDTH-1:0]   in;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic [CW-1:0]      count;
  logic               overflow;
  logic [CNT_W-1:0]   drop_count;

  modport master (
    output in_valid, in, clear, out_ready,
    input  out_valid, out, count, overflow, drop_count
  );

  modport slave (
    input  in_valid, in, clear, out_ready,
    output out_valid, out, count, overflow, drop_count
  );
endinterface

// File: rtl/stm_pair_collector.sv
// Groups consecutive valid words into {phase-B, phase-A} pairs, queues them in a
// small FIFO and counts pairs lost while the FIFO is full and not draining.
module stm_pair_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic                CLK,
  input logic                RST,
  stm_pair_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {PHASE_A, PHASE_B} phase_t;

  phase_t             phase, phase_next;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt;
  logic               ovf;
  logic [CNT_W-1:0]   drops;
  logic               take_lo, pair_done, nonempty, full, pop, push, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Phase is counted in valid words, so idle cycles leave it untouched.
  always_comb begin
    phase_next = phase;
    take_lo    = 1'b0;
    pair_done  = 1'b0;
    if (bus.in_valid) begin
      case (phase)
        PHASE_A: begin
          take_lo    = 1'b1;
          phase_next = PHASE_B;
        end
        PHASE_B: begin
          pair_done  = 1'b1;
          phase_next = PHASE_A;
        end
      endcase
    end
  end

  assign nonempty = (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));
  assign pop      = nonempty & bus.out_ready;
  // A same-cycle pop frees the slot a full FIFO would otherwise refuse.
  assign push     = pair_done & (~full | pop);
  assign drop     = pair_done & full & ~pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= PHASE_A;
      lo    <= '0;
    end else begin
      phase <= phase_next;
      if (take_lo) lo <= bus.in;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {bus.in, lo};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A drop in the clearing cycle wins: it becomes the first counted drop.
      if (drop) begin
        ovf   <= 1'b1;
        drops <= bus.clear ? CNT_W'(1) : sat_inc(drops);
      end else if (bus.clear) begin
        ovf   <= 1'b0;
        drops <= '0;
      end
    end
  end

  assign bus.out_valid  = nonempty;
  assign bus.out        = nonempty ? mem[rd_ptr] : '0;
  assign bus.count      = cnt;
  assign bus.overflow   = ovf;
  assign bus.drop_count = drops;
endmodule

// File: tb/tb_stm_pair_collector.sv
// Directed bench for stm_pair_collector: two instances share one stimulus,
// one with an 8-bit drop counter and one with a 2-bit counter for saturation.
module tb_stm_pair_collector;
  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic [31:0] in_w;
  logic        clear;
  logic        out_ready;
  int          checks;
  int          failures;

  stm_pair_collector_if #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) bus_a ();
  stm_pair_collector_if #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in        = in_w;
  assign bus_a.clear     = clear;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in        = in_w;
  assign bus_b.clear     = clear;
  assign bus_b.out_ready = out_ready;

  stm_pair_collector #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) dut_a (
    .CLK(CLK), .RST(RST), .bus(bus_a)
  );
  stm_pair_collector #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .bus(bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic word(input logic [31:0] w);
    in_valid = 1'b1;
    in_w     = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST       = 1'b1;
    in_valid  = 1'b0;
    in_w      = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_count", 64'(bus_a.count), 64'd0);
    check("rst_overflow", 64'(bus_a.overflow), 64'd0);
    check("rst_drop_count", 64'(bus_a.drop_count), 64'd0);
    check("rst_out", bus_a.out, 64'd0);
    RST = 1'b0;

    // Basic pair with consumer always ready
    out_ready = 1'b1;
    word(32'h11);
    check("basic_no_push_after_a", 64'(bus_a.out_valid), 64'd0);
    word(32'h22);
    check("basic_out_valid", 64'(bus_a.out_valid), 64'd1);
    check("basic_out", bus_a.out, 64'h00000022_00000011);
    check("basic_count", 64'(bus_a.count), 64'd1);
    tick();
    check("basic_popped", 64'(bus_a.out_valid), 64'd0);
    check("basic_count_after_pop", 64'(bus_a.count), 64'd0);

    // Gap tolerance, consumer stalled so the pair is held
    out_ready = 1'b0;
    word(32'hA);
    tick();
    tick();
    tick();
    check("gap_no_push", 64'(bus_a.count), 64'd0);
    word(32'hB);
    check("gap_count", 64'(bus_a.count), 64'd1);
    check("gap_out", bus_a.out, 64'h0000000B_0000000A);
    tick();
    check("gap_hold_out", bus_a.out, 64'h0000000B_0000000A);
    check("gap_hold_valid", 64'(bus_a.out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("gap_drained", 64'(bus_a.count), 64'd0);

    // Fill and drop: five pairs into a four-deep FIFO
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) word(32'h100 + 32'(i));
    check("fill_count", 64'(bus_a.count), 64'd4);
    check("fill_overflow", 64'(bus_a.overflow), 64'd1);
    check("fill_drop_count", 64'(bus_a.drop_count), 64'd1);
    check("fill_drop_count_small", 64'(bus_b.drop_count), 64'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("fill_drain_%0d", k), bus_a.out,
            {32'h100 + 32'(2 * k), 32'h100 + 32'(2 * k - 1)});
      tick();
    end
    check("fill_empty", 64'(bus_a.out_valid), 64'd0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_overflow", 64'(bus_a.overflow), 64'd0);
    check("clear_drop_count", 64'(bus_a.drop_count), 64'd0);

    // Full FIFO with a pop in the cycle the fifth pair completes
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) word(32'h200 + 32'(i));
    out_ready = 1'b1;
    word(32'h20A);
    out_ready = 1'b0;
    check("fullpop_count", 64'(bus_a.count), 64'd4);
    check("fullpop_no_overflow", 64'(bus_a.overflow), 64'd0);
    check("fullpop_no_drop", 64'(bus_a.drop_count), 64'd0);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("fullpop_drain_%0d", k), bus_a.out,
            {32'h200 + 32'(2 * k), 32'h200 + 32'(2 * k - 1)});
      tick();
    end
    check("fullpop_empty", 64'(bus_a.out_valid), 64'd0);

    // Saturation and clear interplay
    out_ready = 1'b0;
    for (int i = 1; i <= 18; i++) word(32'h300 + 32'(i));
    check("sat_drop_count_wide", 64'(bus_a.drop_count), 64'd5);
    check("sat_drop_count_small", 64'(bus_b.drop_count), 64'd3);
    check("sat_overflow_small", 64'(bus_b.overflow), 64'd1);
    word(32'h313);
    clear = 1'b1;
    word(32'h314);
    clear = 1'b0;
    check("clrdrop_count_wide", 64'(bus_a.drop_count), 64'd1);
    check("clrdrop_count_small", 64'(bus_b.drop_count), 64'd1);
    check("clrdrop_overflow", 64'(bus_b.overflow), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_drop_count_small", 64'(bus_b.drop_count), 64'd0);
    check("clr_overflow", 64'(bus_a.overflow), 64'd0);
    check("clr_keeps_fifo", 64'(bus_a.count), 64'd4);
    check("clr_keeps_head", bus_a.out, 64'h00000302_00000301);

    // Asynchronous reset with a held phase-A word and a full FIFO
    word(32'h5);
    #2;
    RST = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("arst_count", 64'(bus_a.count), 64'd0);
    check("arst_out", bus_a.out, 64'd0);
    RST = 1'b0;
    word(32'h6);
    word(32'h7);
    check("arst_pair_valid", 64'(bus_a.out_valid), 64'd1);
    check("arst_pair_out", bus_a.out, 64'h00000007_00000006);
    check("arst_pair_count", 64'(bus_a.count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
